// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the frequency counter BCD datapath: default sizes and FSM encodings.
package bcd_to_binary_pkg;

  localparam int unsigned BCD_DIGITS = 7;
  localparam int unsigned BIN_WIDTH  = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  // 10^n, used to size-check the binary result at elaboration.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_to_binary_digit_mac.sv
// Combinational acc*10 + digit via shift-add, plus a flag for non-decimal digits.
module bcd_digit_mac #(
  parameter int unsigned BIN_W = 32
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] acc_next_c,
  output logic             digit_invalid_c
);

  assign acc_next_c      = (acc << 3) + (acc << 1) + BIN_W'(digit);
  assign digit_invalid_c = (digit > 4'd9);

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter, one digit per clock, most significant digit first.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int unsigned DIGITS = BCD_DIGITS,
  parameter int unsigned BIN_W  = BIN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      binary_out,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  // The largest DIGITS-digit decimal value must fit in BIN_W bits.
  if (BIN_W < 64) begin : g_width_check
    if ((64'(1) << BIN_W) <= (pow10(DIGITS) - 64'(1))) begin : g_too_narrow
      $error("bcd_to_binary: BIN_W too small for DIGITS");
    end
  end

  logic [0:0]       state, state_nxt;
  logic [BIN_W-1:0] acc, acc_nxt;
  logic [BCD_W-1:0] shift, shift_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             err_acc, err_acc_nxt;
  logic [BIN_W-1:0] binary_nxt;
  logic             done_nxt, busy_nxt, err_nxt;

  logic [3:0]       digit;
  logic [BIN_W-1:0] mac_c;
  logic             digit_bad_c;

  assign digit = shift[BCD_W-1 -: 4];

  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .acc             (acc),
    .digit           (digit),
    .acc_next_c      (mac_c),
    .digit_invalid_c (digit_bad_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      acc        <= '0;
      shift      <= '0;
      count      <= '0;
      err_acc    <= 1'b0;
      binary_out <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      shift      <= shift_nxt;
      count      <= count_nxt;
      err_acc    <= err_acc_nxt;
      binary_out <= binary_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
      err        <= err_nxt;
    end
  end

  // Next-state and next-output logic; done defaults low so it is a single-cycle pulse.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    shift_nxt   = shift;
    count_nxt   = count;
    err_acc_nxt = err_acc;
    binary_nxt  = binary_out;
    err_nxt     = err;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          shift_nxt   = bcd_in;
          acc_nxt     = '0;
          count_nxt   = CNT_W'(DIGITS);
          err_acc_nxt = 1'b0;
          busy_nxt    = 1'b1;
          state_nxt   = ST_CONV;
        end
      end
      ST_CONV: begin
        acc_nxt     = mac_c;
        shift_nxt   = shift << 4;
        err_acc_nxt = err_acc | digit_bad_c;
        count_nxt   = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          binary_nxt = mac_c;
          err_nxt    = err_acc | digit_bad_c;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: directed cases plus random loopback against a behavioural model.
module tb_bcd_to_binary;

  localparam int unsigned DIGITS = 7;
  localparam int unsigned BIN_W  = 32;
  localparam int unsigned BCD_W  = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [BCD_W-1:0] bcd_in;
  logic [BIN_W-1:0] binary_out;
  logic             done, busy, err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bcd_in     (bcd_in),
    .binary_out (binary_out),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Decimal weight of each nibble, digits 10..15 taken at face value.
  function automatic logic [BIN_W-1:0] bcd_value(input logic [BCD_W-1:0] b);
    longint unsigned v, w;
    v = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v = v + 64'(b[4*i +: 4]) * w;
      w = w * 10;
    end
    return BIN_W'(v);
  endfunction

  function automatic bit has_bad(input logic [BCD_W-1:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned val);
    logic [BCD_W-1:0] r;
    int unsigned      x;
    r = '0;
    x = val;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Behavioural model: a conversion accepted when idle completes DIGITS edges later.
  int               rem_m;
  logic [BIN_W-1:0] pend_v, out_m;
  logic             pend_e, err_m, done_m, busy_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_m  <= 0;
      pend_v <= '0;
      pend_e <= 1'b0;
      out_m  <= '0;
      err_m  <= 1'b0;
      done_m <= 1'b0;
      busy_m <= 1'b0;
    end else begin
      done_m <= 1'b0;
      if (rem_m == 0) begin
        if (start) begin
          pend_v <= bcd_value(bcd_in);
          pend_e <= has_bad(bcd_in);
          rem_m  <= DIGITS;
          busy_m <= 1'b1;
        end
      end else begin
        rem_m <= rem_m - 1;
        if (rem_m == 1) begin
          out_m  <= pend_v;
          err_m  <= pend_e;
          done_m <= 1'b1;
          busy_m <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_done", 64'(done), 64'(done_m));
      chk("cyc_busy", 64'(busy), 64'(busy_m));
      chk("cyc_binary_out", 64'(binary_out), 64'(out_m));
      chk("cyc_err", 64'(err), 64'(err_m));
    end
  end

  // Wait for done starting from a negedge k edges after acceptance; bounded.
  task automatic wait_done(input int k0, input bit noise, output int k);
    k = k0;
    do begin
      if (noise && k < 6) begin
        start  = 1'($urandom);
        bcd_in = BCD_W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end while (!done && k < 20);
  endtask

  // Called at a negedge; returns at the negedge where done is high.
  task automatic run_conv(input logic [BCD_W-1:0] b, input logic [BIN_W-1:0] exp_v,
                          input bit exp_e, input bit noise, input string name);
    int k;
    start  = 1'b1;
    bcd_in = b;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = BCD_W'($urandom);
    chk({name, "_busy"}, 64'(busy), 64'd1);
    wait_done(0, noise, k);
    chk({name, "_latency"}, 64'(k), 64'd7);
    chk({name, "_value"}, 64'(binary_out), 64'(exp_v));
    chk({name, "_err"}, 64'(err), 64'(exp_e));
    chk({name, "_model"}, 64'(out_m), 64'(exp_v));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    int unsigned v;
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_binary_out", 64'(binary_out), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv(28'h0012345, 32'd12345, 1'b0, 1'b0, "d12345");
    run_conv(28'h9999999, 32'd9999999, 1'b0, 1'b0, "d9999999");
    run_conv(28'h0000000, 32'd0, 1'b0, 1'b0, "d0");
    run_conv(28'h00A0001, 32'd100001, 1'b1, 1'b0, "bad_digit");
    @(negedge clk);

    // Start pulsed mid-conversion is ignored; start on the done cycle is accepted.
    start  = 1'b1;
    bcd_in = 28'h0000007;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start  = 1'b1;
    bcd_in = 28'h0000042;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, 1'b0, k);
    chk("ignore_latency", 64'(k), 64'd7);
    chk("ignore_value", 64'(binary_out), 64'd7);
    run_conv(28'h0000042, 32'd42, 1'b0, 1'b0, "on_done");
    @(negedge clk);

    // Asynchronous reset in the middle of a conversion.
    start  = 1'b1;
    bcd_in = 28'h7654321;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_binary_out", 64'(binary_out), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("postrst_no_done", 64'(done), 64'd0);
    end
    run_conv(28'h1234567, 32'd1234567, 1'b0, 1'b0, "after_rst");

    // Random loopback through a binary-to-BCD conversion.
    for (int n = 0; n < 1000; n++) begin
      v = $urandom_range(9999999, 0);
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
      run_conv(to_bcd(v), BIN_W'(v), 1'b0, 1'b1, "loop");
    end

    repeat (10) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
